// File: rtl/multicycle_main_control.sv
// Multicycle main control: Moore FSM sequencing one instruction at a time (3-5 cycles incl. FETCH).
// No flow control; the datapath follows the state-decoded enables every cycle.
module multicycle_main_control #(
  parameter bit ENABLE_ADDI = 1'b1,
  parameter bit ENABLE_J    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       pc_en,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t cur, nxt, dec;
  logic   is_lw, is_sw, is_r, is_beq, is_addi, is_j, legal;
  logic   pcwrite, branch;

  always_comb begin
    is_lw   = (opcode == OP_LW);
    is_sw   = (opcode == OP_SW);
    is_r    = (opcode == OP_RTYPE);
    is_beq  = (opcode == OP_BEQ);
    is_addi = (opcode == OP_ADDI) && ENABLE_ADDI;
    is_j    = (opcode == OP_J) && ENABLE_J;
    legal   = is_lw | is_sw | is_r | is_beq | is_addi | is_j;
  end

  // illegal_op is a pure one-shot: it reloads every edge, so it lives only in the FETCH after DECODE
  always_ff @(posedge clk) begin
    if (reset) begin
      cur        <= FETCH;
      illegal_op <= 1'b0;
    end else begin
      cur        <= nxt;
      illegal_op <= (cur == DECODE) && !legal;
    end
  end

  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:  nxt = DECODE;
      DECODE: begin
        if (is_lw || is_sw) nxt = MEMADR;
        else if (is_r)      nxt = EXEC;
        else if (is_beq)    nxt = BRANCH;
        else if (is_addi)   nxt = ADDIEX;
        else if (is_j)      nxt = JUMP;
        else                nxt = FETCH;
      end
      MEMADR: nxt = is_lw ? MEMRD : MEMWR;
      MEMRD:  nxt = MEMWB;
      EXEC:   nxt = ALUWB;
      ADDIEX: nxt = ADDIWB;
      default: nxt = FETCH;
    endcase
  end

  // Under reset the selects present FETCH values while every write strobe is held off
  always_comb begin
    dec      = reset ? FETCH : cur;
    iord     = 1'b0;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluop    = 2'b00;
    pcsrc    = 2'b00;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    case (dec)
      FETCH: begin
        irwrite = 1'b1;
        pcwrite = 1'b1;
        alusrcb = 2'b01;
      end
      DECODE: alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:  iord = 1'b1;
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        branch  = 1'b1;
        pcsrc   = 2'b01;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB: regwrite = 1'b1;
      JUMP: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
      end
      default: ;
    endcase
    if (reset) begin
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
    end
  end

  assign pc_en = pcwrite | (branch & zero);
  assign state = cur;

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Multicycle main control FSM: issues the 2-bit ALUOp code consumed by the ALU control decoder, plus all datapath enables and mux selects, one instruction at a time.
- Sits between the instruction register opcode field and the shared-ALU / shared-memory multicycle datapath.
- Supports LW, SW, R-type, BEQ, ADDI and J.
- ALUOp encoding:
  - 00: add (address and PC arithmetic)
  - 01: subtract (branch compare)
  - 10: R-type, ALU operation selected by Funct

Parameters:
- ENABLE_ADDI, 1: when 0, opcode 001000 is treated as illegal.
- ENABLE_J, 1: when 0, opcode 000010 is treated as illegal.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  6  instruction register bits [31:26], valid from DECODE onward.
- zero  input  1  ALU zero flag.
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- irwrite  output  1  instruction register load.
- memwrite  output  1  data memory write.
- regwrite  output  1  register file write.
- regdst  output  1  write register select: 1 = rd, 0 = rt.
- memtoreg  output  1  write-back data select: 1 = memory data, 0 = ALUOut.
- alusrca  output  1  ALU A select: 0 = PC, 1 = register A.
- alusrcb  output  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- aluop  output  2  to the ALU control decoder.
- pcsrc  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- pc_en  output  1  PC load enable, equal to pcwrite OR (branch AND zero).
- state  output  4  current state, for debug.
- illegal_op  output  1  one-cycle flag for an unsupported opcode.

Behaviour:
- Moore FSM, 4-bit state register. All outputs except pc_en and illegal_op decode from state alone. Any output not listed for a state is 0.
  - FETCH (0): irwrite=1, pcwrite=1, alusrcb=01, aluop=00, iord=0, pcsrc=00.
  - DECODE (1): alusrcb=11, aluop=00 (branch target precomputed into ALUOut).
  - MEMADR (2): alusrca=1, alusrcb=10, aluop=00.
  - MEMRD (3): iord=1.
  - MEMWB (4): regwrite=1, memtoreg=1, regdst=0.
  - MEMWR (5): iord=1, memwrite=1.
  - EXEC (6): alusrca=1, alusrcb=00, aluop=10.
  - ALUWB (7): regwrite=1, regdst=1, memtoreg=0.
  - BRANCH (8): alusrca=1, alusrcb=00, aluop=01, branch=1, pcsrc=01.
  - ADDIEX (9): alusrca=1, alusrcb=10, aluop=00.
  - ADDIWB (10): regwrite=1, regdst=0, memtoreg=0.
  - JUMP (11): pcwrite=1, pcsrc=10.
- Transitions:
  - FETCH to DECODE, always.
  - DECODE, by opcode:
    - 100011 (LW) or 101011 (SW) to MEMADR.
    - 000000 (R-type) to EXEC.
    - 000100 (BEQ) to BRANCH.
    - 001000 (ADDI) to ADDIEX.
    - 000010 (J) to JUMP.
    - Anything else to FETCH.
  - MEMADR to MEMRD if the opcode is LW, else to MEMWR.
  - MEMRD to MEMWB.
  - EXEC to ALUWB.
  - ADDIEX to ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP all return to FETCH.
  - Unused encodings 12-15 go to FETCH on the next edge. Their outputs are all 0.
- Instruction latency, counting FETCH: LW 5 cycles; SW, R-type and ADDI 4 cycles; BEQ and J 3 cycles.
- opcode is sampled only in DECODE and MEMADR. The datapath holds the IR stable from DECODE until the return to FETCH.
- pc_en is combinational: pcwrite OR (branch AND zero). zero is relevant only in BRANCH.
- illegal_op is registered:
  - Set at the clock edge that leaves DECODE with an illegal opcode.
  - Cleared at the next edge, so it is high for exactly the one following FETCH cycle.
  - Opcodes disabled by a parameter count as illegal.
- Reset:
  - While reset is high, state loads FETCH on each edge and illegal_op loads 0.
  - During reset, irwrite, pcwrite, pc_en, memwrite and regwrite are forced to 0. Mux selects and aluop show the FETCH values.
  - Reset asserted mid-instruction aborts it. The first cycle after reset deasserts is a full FETCH with writes enabled.

Test Plan:
- Reset held 2 cycles with opcode=100011, then released: state=0 during reset with irwrite=pc_en=memwrite=regwrite=0. After release the states run 0,1,2,3,4,0; aluop=00 throughout; regwrite=1 and memtoreg=1 only in state 4.
- opcode=000000: states 0,1,6,7,0. aluop=10 in state 6. regwrite=1 and regdst=1 in state 7.
- opcode=000100 with zero=1 in BRANCH: states 0,1,8,0, aluop=01 and pc_en=1 in state 8. Repeat with zero=0: pc_en=0 in state 8.
- opcode=101011: states 0,1,2,5,0. memwrite=1 and iord=1 only in state 5; regwrite stays 0.
- opcode=111111: states 0,1,0; illegal_op=1 for exactly the one cycle after DECODE. Repeat with ENABLE_J=0 and opcode=000010: same result.
- Reset asserted while in state 3 of an LW: next state=0 and regwrite never asserts. After release, the sequence restarts cleanly from FETCH.
